// File: rtl/dbus_pkg.sv
// Shared address map, state encoding and decode helper for the data-bus bridge.
package dbus_pkg;

    localparam logic [31:0] PERIPH_BASE  = 32'h1000_0000;
    localparam logic [31:0] PERIPH_LIMIT = 32'h1000_0FFF;
    localparam logic [31:0] DEADBEEF_VAL = 32'hDEAD_BEEF;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RAM_RD   = 3'd1,
        P_SETUP  = 3'd2,
        P_ACCESS = 3'd3,
        RESP     = 3'd4
    } state_e;

    typedef enum logic [1:0] {
        REG_RAM      = 2'd0,
        REG_PERIPH   = 2'd1,
        REG_UNMAPPED = 2'd2
    } region_e;

    // RAM occupies the bottom 4*2^ram_aw bytes; everything else outside the periph window is unmapped.
    function automatic region_e decode(input logic [31:0] addr, input int ram_aw);
        if ((addr >> (ram_aw + 2)) == 32'd0)
            return REG_RAM;
        else if (addr >= PERIPH_BASE && addr <= PERIPH_LIMIT)
            return REG_PERIPH;
        else
            return REG_UNMAPPED;
    endfunction

endpackage

// File: rtl/dbus_periph_port.sv
// Two-phase peripheral port: latches the request, sequences setup/access strobes
// and forces completion when the peripheral stalls too long.
module dbus_periph_port
    import dbus_pkg::*;
#(
    parameter int TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rstb,
    input  logic        start_i,
    input  logic [11:0] addr_i,
    input  logic        write_i,
    input  logic [3:0]  be_i,
    input  logic [31:0] wdata_i,
    input  logic        setup_i,
    input  logic        access_i,
    input  logic [31:0] p_rdata,
    input  logic        p_ready,
    output logic        p_sel,
    output logic        p_enable,
    output logic        p_write,
    output logic [11:0] p_addr,
    output logic [3:0]  p_be,
    output logic [31:0] p_wdata,
    output logic        done_o,
    output logic        timeout_o,
    output logic [31:0] rdata_o
);

    localparam logic [3:0] TIMEOUT_CNT = 4'(TIMEOUT);

    logic [3:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (setup_i)
            cnt_d = 4'd0;
        else if (access_i)
            cnt_d = cnt_q + 4'd1;
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            cnt_q   <= 4'd0;
            p_write <= 1'b0;
            p_addr  <= 12'd0;
            p_be    <= 4'd0;
            p_wdata <= 32'd0;
        end else begin
            cnt_q <= cnt_d;
            if (start_i) begin
                p_write <= write_i;
                p_addr  <= addr_i;
                p_be    <= be_i;
                p_wdata <= wdata_i;
            end
        end
    end

    // The timeout cycle itself is not a bus cycle: strobes are withdrawn and p_ready ignored.
    assign timeout_o = access_i && (cnt_q == TIMEOUT_CNT);
    assign done_o    = access_i && (timeout_o || p_ready);
    assign rdata_o   = timeout_o ? DEADBEEF_VAL : p_rdata;
    assign p_sel     = setup_i || (access_i && !timeout_o);
    assign p_enable  = access_i && !timeout_o;

endmodule

// File: rtl/dbus_bridge.sv
// Core data-bus bridge: decodes each request to RAM, peripheral or unmapped space
// and returns single-cycle ready pulses to the core.
module dbus_bridge
    import dbus_pkg::*;
#(
    parameter int RAM_AW  = 14,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rstb,
    input  logic [31:0]       d_addr,
    input  logic              d_rd_req,
    input  logic              d_wr_req,
    input  logic [3:0]        d_wr_be,
    input  logic [31:0]       d_wr_data,
    output logic              d_rd_ready,
    output logic              d_wr_ready,
    output logic [31:0]       d_rd_data,
    output logic              ram_cs,
    output logic              ram_we,
    output logic [RAM_AW-1:0] ram_addr,
    output logic [3:0]        ram_be,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata,
    output logic              p_sel,
    output logic              p_enable,
    output logic              p_write,
    output logic [11:0]       p_addr,
    output logic [3:0]        p_be,
    output logic [31:0]       p_wdata,
    input  logic [31:0]       p_rdata,
    input  logic              p_ready,
    output logic              bus_err
);

    state_e  state_q, state_d;
    logic    op_wr_q, op_wr_d;
    logic    bus_err_q, bus_err_d;
    region_e region;
    logic    accept, sel_wr, p_start;
    logic    p_done, p_timeout;
    logic [31:0] p_rdata_mux;

    // Gating with rstb keeps every strobe low while reset is held.
    assign region    = decode(d_addr, RAM_AW);
    assign accept    = rstb && (d_rd_req || d_wr_req) && (state_q == IDLE);
    assign sel_wr    = !d_rd_req;
    assign ram_addr  = d_addr[RAM_AW+1:2];
    assign ram_be    = d_wr_be;
    assign ram_wdata = d_wr_data;
    assign bus_err   = bus_err_q;

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state_q   <= IDLE;
            op_wr_q   <= 1'b0;
            bus_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_wr_q   <= op_wr_d;
            bus_err_q <= bus_err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        op_wr_d   = op_wr_q;
        bus_err_d = bus_err_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    op_wr_d = sel_wr;
                    case (region)
                        REG_RAM:    if (!sel_wr) state_d = RAM_RD;
                        REG_PERIPH: state_d = P_SETUP;
                        default:    state_d = RESP;
                    endcase
                end
            end
            RAM_RD:  state_d = IDLE;
            P_SETUP: state_d = P_ACCESS;
            P_ACCESS: begin
                if (p_done)
                    state_d = IDLE;
                if (p_timeout)
                    bus_err_d = 1'b1;
            end
            RESP: begin
                state_d   = IDLE;
                bus_err_d = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ram_cs     = 1'b0;
        ram_we     = 1'b0;
        d_rd_ready = 1'b0;
        d_wr_ready = 1'b0;
        d_rd_data  = 32'd0;
        p_start    = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept && region == REG_RAM) begin
                    ram_cs     = 1'b1;
                    ram_we     = sel_wr;
                    d_wr_ready = sel_wr;
                end
                p_start = accept && (region == REG_PERIPH);
            end
            RAM_RD: begin
                d_rd_ready = 1'b1;
                d_rd_data  = ram_rdata;
            end
            P_ACCESS: begin
                if (p_done) begin
                    d_wr_ready = op_wr_q;
                    d_rd_ready = !op_wr_q;
                    d_rd_data  = op_wr_q ? 32'd0 : p_rdata_mux;
                end
            end
            RESP: begin
                d_wr_ready = op_wr_q;
                d_rd_ready = !op_wr_q;
            end
            default: ;
        endcase
    end

    dbus_periph_port #(.TIMEOUT(TIMEOUT)) u_periph (
        .clk       (clk),
        .rstb      (rstb),
        .start_i   (p_start),
        .addr_i    (d_addr[11:0]),
        .write_i   (sel_wr),
        .be_i      (d_wr_be),
        .wdata_i   (d_wr_data),
        .setup_i   (state_q == P_SETUP),
        .access_i  (state_q == P_ACCESS),
        .p_rdata   (p_rdata),
        .p_ready   (p_ready),
        .p_sel     (p_sel),
        .p_enable  (p_enable),
        .p_write   (p_write),
        .p_addr    (p_addr),
        .p_be      (p_be),
        .p_wdata   (p_wdata),
        .done_o    (p_done),
        .timeout_o (p_timeout),
        .rdata_o   (p_rdata_mux)
    );

endmodule

// File: tb/tb_dbus_bridge.sv
// Directed bench for dbus_bridge with a behavioural synchronous RAM and a hand-driven peripheral.
module tb_dbus_bridge;

    localparam int RAM_AW  = 14;
    localparam int TIMEOUT = 15;

    logic              clk = 1'b0;
    logic              rstb;
    logic [31:0]       d_addr;
    logic              d_rd_req, d_wr_req;
    logic [3:0]        d_wr_be;
    logic [31:0]       d_wr_data;
    logic              d_rd_ready, d_wr_ready;
    logic [31:0]       d_rd_data;
    logic              ram_cs, ram_we;
    logic [RAM_AW-1:0] ram_addr;
    logic [3:0]        ram_be;
    logic [31:0]       ram_wdata;
    logic [31:0]       ram_rdata;
    logic              p_sel, p_enable, p_write;
    logic [11:0]       p_addr;
    logic [3:0]        p_be;
    logic [31:0]       p_wdata, p_rdata;
    logic              p_ready;
    logic              bus_err;

    int checks = 0;
    int errors = 0;
    int n;

    dbus_bridge #(.RAM_AW(RAM_AW), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rstb(rstb),
        .d_addr(d_addr), .d_rd_req(d_rd_req), .d_wr_req(d_wr_req),
        .d_wr_be(d_wr_be), .d_wr_data(d_wr_data),
        .d_rd_ready(d_rd_ready), .d_wr_ready(d_wr_ready), .d_rd_data(d_rd_data),
        .ram_cs(ram_cs), .ram_we(ram_we), .ram_addr(ram_addr), .ram_be(ram_be),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
        .p_sel(p_sel), .p_enable(p_enable), .p_write(p_write), .p_addr(p_addr),
        .p_be(p_be), .p_wdata(p_wdata), .p_rdata(p_rdata), .p_ready(p_ready),
        .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    // Synchronous RAM model: data appears the cycle after a read strobe.
    logic [31:0] mem [0:(2**RAM_AW)-1];
    always @(posedge clk) begin
        if (ram_cs) begin
            if (ram_we) begin
                for (int b = 0; b < 4; b++)
                    if (ram_be[b]) mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
            end else begin
                ram_rdata <= mem[ram_addr];
            end
        end
    end

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    initial begin
        rstb = 1'b0; d_addr = 32'd0; d_rd_req = 1'b1; d_wr_req = 1'b0;
        d_wr_be = 4'hF; d_wr_data = 32'd0; p_rdata = 32'd0; p_ready = 1'b0;

        // Reset: strobes held low even with a request pending
        smp();
        chk1("rst_ram_cs", ram_cs, 1'b0);
        chk1("rst_rd_ready", d_rd_ready, 1'b0);
        chk1("rst_wr_ready", d_wr_ready, 1'b0);
        chk1("rst_p_sel", p_sel, 1'b0);
        chk1("rst_bus_err", bus_err, 1'b0);
        chk32("rst_p_addr", {20'd0, p_addr}, 32'h0);
        chk32("rst_rd_data", d_rd_data, 32'h0);
        cyc(); cyc();
        d_rd_req = 1'b0; rstb = 1'b1;

        // Zero-wait RAM store then load
        cyc(); d_wr_req = 1'b1; d_addr = 32'h10; d_wr_data = 32'hA5A5_1234; d_wr_be = 4'hF;
        smp();
        chk1("st_wr_ready", d_wr_ready, 1'b1);
        chk1("st_ram_we", ram_we, 1'b1);
        chk1("st_ram_cs", ram_cs, 1'b1);
        chk32("st_ram_addr", {18'd0, ram_addr}, 32'h4);
        cyc(); d_wr_req = 1'b0; d_rd_req = 1'b1;
        smp();
        chk1("ld_ram_cs", ram_cs, 1'b1);
        chk1("ld_ram_we", ram_we, 1'b0);
        chk1("ld_early_ready", d_rd_ready, 1'b0);
        chk32("ld_idle_data", d_rd_data, 32'h0);
        cyc(); d_rd_req = 1'b0;
        smp();
        chk1("ld_ready", d_rd_ready, 1'b1);
        chk32("ld_data", d_rd_data, 32'hA5A5_1234);
        cyc(); smp();
        chk1("ld_ready_pulse", d_rd_ready, 1'b0);

        // Back-to-back stores, then a partial-byte store into word 2
        cyc(); d_wr_req = 1'b1; d_addr = 32'h4; d_wr_data = 32'h1111_0004;
        smp(); chk1("bst0_ready", d_wr_ready, 1'b1);
        cyc(); d_addr = 32'h8; d_wr_data = 32'h2222_0008;
        smp(); chk1("bst1_ready", d_wr_ready, 1'b1);
        cyc(); d_wr_be = 4'h2; d_wr_data = 32'h0000_AB00;
        smp(); chk32("bst2_be", {28'd0, ram_be}, 32'h2);

        // Back-to-back loads with d_rd_req held high
        cyc(); d_wr_req = 1'b0; d_wr_be = 4'hF; d_rd_req = 1'b1; d_addr = 32'h4;
        smp(); chk1("bld0_wait", d_rd_ready, 1'b0);
        cyc(); d_addr = 32'h8;
        smp(); chk1("bld0_ready", d_rd_ready, 1'b1);
        chk32("bld0_data", d_rd_data, 32'h1111_0004);
        cyc();
        smp(); chk1("bld1_gap", d_rd_ready, 1'b0);
        cyc(); d_rd_req = 1'b0;
        smp(); chk1("bld1_ready", d_rd_ready, 1'b1);
        chk32("bld1_data", d_rd_data, 32'h2222_AB08);

        // Read wins over a simultaneous write; write served afterwards
        cyc(); d_rd_req = 1'b1; d_wr_req = 1'b1; d_addr = 32'h10; d_wr_data = 32'hFFFF_FFFF;
        smp(); chk1("prio_no_wr", d_wr_ready, 1'b0);
        chk1("prio_rd_strobe", ram_we, 1'b0);
        cyc(); d_rd_req = 1'b0;
        smp(); chk32("prio_rd_data", d_rd_data, 32'hA5A5_1234);
        chk1("prio_wr_wait", d_wr_ready, 1'b0);
        cyc();
        smp(); chk1("prio_wr_ready", d_wr_ready, 1'b1);
        cyc(); d_wr_req = 1'b0;

        // Peripheral read, p_ready on the 4th access cycle
        cyc(); d_rd_req = 1'b1; d_addr = 32'h1000_0004; p_rdata = 32'h1234_5678;
        smp(); chk1("pr_idle_psel", p_sel, 1'b0);
        chk1("pr_idle_ramcs", ram_cs, 1'b0);
        n = 0;
        for (int i = 1; i <= 5; i++) begin
            cyc(); d_rd_req = 1'b0; d_addr = 32'h0; p_ready = (i == 5);
            smp();
            if (p_sel) n++;
            chk1("pr_enable", p_enable, (i >= 2));
            chk1("pr_ready", d_rd_ready, (i == 5));
            chk32("pr_data", d_rd_data, (i == 5) ? 32'h1234_5678 : 32'h0);
        end
        chk32("pr_p_addr", {20'd0, p_addr}, 32'h004);
        cyc(); p_ready = 1'b0;
        smp(); if (p_sel) n++;
        chk32("pr_psel_cycles", n, 32'd5);
        chk1("pr_bus_err", bus_err, 1'b0);

        // Peripheral write with stuck p_ready: forced completion
        cyc(); d_wr_req = 1'b1; d_addr = 32'h1000_0008; d_wr_data = 32'hCAFE_0001; d_wr_be = 4'h3;
        smp(); chk1("pw_idle_ready", d_wr_ready, 1'b0);
        cyc(); d_wr_req = 1'b0; d_wr_data = 32'h0; d_wr_be = 4'h0; d_addr = 32'h0;
        smp();
        chk1("pw_setup_sel", p_sel, 1'b1);
        chk1("pw_setup_en", p_enable, 1'b0);
        chk1("pw_write", p_write, 1'b1);
        chk32("pw_wdata", p_wdata, 32'hCAFE_0001);
        chk32("pw_be", {28'd0, p_be}, 32'h3);
        chk32("pw_addr", {20'd0, p_addr}, 32'h008);
        n = 0;
        for (int i = 0; i < TIMEOUT; i++) begin
            cyc(); smp();
            if (p_sel && p_enable && !d_wr_ready) n++;
        end
        chk32("pw_access_cycles", n, TIMEOUT);
        cyc(); smp();
        chk1("pw_forced_ready", d_wr_ready, 1'b1);
        chk1("pw_forced_psel", p_sel, 1'b0);
        chk1("pw_forced_rd", d_rd_ready, 1'b0);
        cyc(); smp();
        chk1("pw_bus_err", bus_err, 1'b1);
        chk1("pw_ready_pulse", d_wr_ready, 1'b0);

        // Peripheral read timeout returns the poison word
        cyc(); d_rd_req = 1'b1; d_addr = 32'h1000_0000;
        cyc(); d_rd_req = 1'b0;
        repeat (TIMEOUT + 1) cyc();
        smp();
        chk1("prt_ready", d_rd_ready, 1'b1);
        chk32("prt_data", d_rd_data, 32'hDEAD_BEEF);

        // Reset in the middle of a peripheral access
        cyc(); d_rd_req = 1'b1; d_addr = 32'h1000_0010;
        cyc(); d_rd_req = 1'b0;
        cyc(); cyc();
        smp(); chk1("rm_access_sel", p_sel, 1'b1);
        #1; rstb = 1'b0; p_ready = 1'b1;
        #1;
        chk1("rm_psel", p_sel, 1'b0);
        chk1("rm_penable", p_enable, 1'b0);
        chk1("rm_ready", d_rd_ready, 1'b0);
        chk1("rm_bus_err", bus_err, 1'b0);
        cyc(); cyc(); p_ready = 1'b0; rstb = 1'b1;
        cyc(); d_rd_req = 1'b1; d_addr = 32'h10;
        smp(); chk1("rm_ld_cs", ram_cs, 1'b1);
        cyc(); d_rd_req = 1'b0;
        smp(); chk1("rm_ld_ready", d_rd_ready, 1'b1);
        chk32("rm_ld_data", d_rd_data, 32'hFFFF_FFFF);

        // Unmapped load
        cyc(); d_rd_req = 1'b1; d_addr = 32'h2000_0000;
        smp(); chk1("um_ram_cs", ram_cs, 1'b0);
        chk1("um_psel", p_sel, 1'b0);
        chk1("um_early", d_rd_ready, 1'b0);
        cyc(); d_rd_req = 1'b0;
        smp(); chk1("um_ready", d_rd_ready, 1'b1);
        chk32("um_data", d_rd_data, 32'h0);
        chk1("um_resp_psel", p_sel, 1'b0);
        cyc(); smp();
        chk1("um_bus_err", bus_err, 1'b1);

        // RAM boundary: last word maps, first word beyond it does not
        cyc(); d_wr_req = 1'b1; d_addr = 32'h0000_FFFC; d_wr_data = 32'h0BAD_CAFE;
        smp(); chk1("bd_top_ready", d_wr_ready, 1'b1);
        chk32("bd_top_addr", {18'd0, ram_addr}, 32'h3FFF);
        cyc(); d_addr = 32'h0001_0000;
        smp(); chk1("bd_over_cs", ram_cs, 1'b0);
        chk1("bd_over_ready", d_wr_ready, 1'b0);
        cyc(); d_wr_req = 1'b0;
        smp(); chk1("bd_over_resp", d_wr_ready, 1'b1);
        chk1("bd_over_rd", d_rd_ready, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dbus_bridge.md
DBUS_BRIDGE -- requirements
Module: dbus_bridge

Interface
REQ-001 SHALL have parameter RAM_AW, default 14, meaning RAM word-address width (64 KiB).
REQ-002 SHALL have parameter TIMEOUT, default 15, meaning maximum peripheral wait cycles before forced completion.
REQ-003 SHALL have port clk  in  1  clock; all state updates on its rising edge.
REQ-004 SHALL have port rstb  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have core-side ports: d_addr in 32; d_rd_req in 1; d_wr_req in 1; d_wr_be in 4; d_wr_data in 32.
REQ-006 SHALL have core-side outputs: d_rd_ready out 1; d_wr_ready out 1; d_rd_data out 32.
REQ-007 SHALL have RAM ports: ram_cs out 1; ram_we out 1; ram_addr out RAM_AW (word address); ram_be out 4; ram_wdata out 32; ram_rdata in 32 (valid one cycle after ram_cs with ram_we=0).
REQ-008 SHALL have peripheral ports: p_sel out 1; p_enable out 1; p_write out 1; p_addr out 12; p_be out 4; p_wdata out 32; p_rdata in 32; p_ready in 1.
REQ-009 SHALL have port bus_err out 1, sticky unmapped/timeout flag.

Function
REQ-010 SHALL decode the address map: RAM = d_addr below 4*2^RAM_AW; PERIPH = 0x1000_0000..0x1000_0FFF; all other addresses are UNMAPPED.
REQ-011 SHALL implement FSM states IDLE, RAM_RD, P_SETUP, P_ACCESS, RESP.
REQ-012 In IDLE, a request SHALL be accepted whenever d_rd_req or d_wr_req is high; if both are high, the read SHALL be served first and the write SHALL wait.
REQ-013 A RAM write SHALL complete with zero wait states: ram_cs=ram_we=1 and d_wr_ready=1 combinationally in the same IDLE cycle, with ram_be=d_wr_be and ram_wdata=d_wr_data.
REQ-014 A RAM read SHALL drive ram_cs=1, ram_we=0 in IDLE and move to RAM_RD.
REQ-015 In RAM_RD, the block SHALL pulse d_rd_ready=1 for one cycle with d_rd_data=ram_rdata, then return to IDLE.
REQ-016 A PERIPH access SHALL register p_addr=d_addr[11:0], p_write, p_be and p_wdata in IDLE.
REQ-017 The PERIPH access SHALL then spend one cycle in P_SETUP (p_sel=1, p_enable=0), followed by P_ACCESS (p_sel=1, p_enable=1) until p_ready=1.
REQ-018 When p_ready=1 in P_ACCESS, the block SHALL pulse the matching ready that cycle, with d_rd_data=p_rdata for reads, then return to IDLE.
REQ-019 A 4-bit wait counter SHALL clear on entry to P_ACCESS and increment each cycle there; when it reaches TIMEOUT without p_ready, the block SHALL force ready and return d_rd_data=0xDEAD_BEEF.
REQ-020 On the forced completion of REQ-019, the block SHALL set bus_err, drop p_sel in that cycle and return to IDLE.
REQ-021 An UNMAPPED access SHALL go from IDLE to RESP and pulse ready in RESP, with d_rd_data=0 and no RAM or peripheral strobe.
REQ-022 An UNMAPPED access SHALL set bus_err; bus_err SHALL be cleared only by reset.
REQ-023 Ready outputs SHALL be single-cycle pulses; a request still high in the cycle after a ready pulse SHALL be treated as a new transaction (back-to-back loads/stores).
REQ-024 d_rd_data SHALL be 0 in every cycle where d_rd_ready=0.
REQ-025 ram_addr SHALL equal d_addr[RAM_AW+1:2]; byte lanes are selected solely by the be signals.
REQ-026 d_addr, d_wr_data and d_wr_be SHALL be sampled only in IDLE; changes during wait states SHALL be ignored.

Reset
REQ-027 While rstb=0, the FSM SHALL be IDLE, the counter 0, and bus_err 0.
REQ-028 While rstb=0, all strobes, readies and p_* registers SHALL be 0.
REQ-029 Reset asserted mid-transaction SHALL abort it immediately with no ready pulse; the first request after release SHALL be accepted normally.

Structure
REQ-030 Package dbus_pkg SHALL hold the address-map base/limit constants, DEADBEEF_VAL and the state enum type.
REQ-031 The peripheral setup/access/timeout logic SHALL be one sub-module, dbus_periph_port; the decode and RAM path SHALL stay in dbus_bridge.

Verification
REQ-032 Store 0xA5A5_1234 to 0x0000_0010 with be=4'hF, then load the same address -> write ready in the same cycle; read ready 1 cycle after the request with data 0xA5A5_1234.
REQ-033 Back-to-back loads to 0x4 and 0x8 with d_rd_req held high -> two separate ready pulses 2 cycles apart, each with the correct data.
REQ-034 Read 0x1000_0004 with p_ready delayed 3 cycles -> p_sel for 5 cycles (setup plus 4 access cycles); ready on the p_ready cycle; data=p_rdata.
REQ-035 Peripheral write with p_ready stuck at 0 -> forced ready after TIMEOUT=15 access cycles; bus_err=1.
REQ-036 Load from 0x2000_0000 -> ready in RESP 1 cycle later; d_rd_data=0; no ram_cs or p_sel; bus_err=1.
REQ-037 Assert rstb=0 during P_ACCESS -> p_sel and ready drop at once, bus_err=0; a following RAM load completes normally.
